// File: rtl/systolic_result_deskew_if.sv
// systolic_result_deskew_if
// Bundles the row stream entering and leaving the deskew block.
//   IN_VALID  : column-0 element of a result row is present on Inputs[0]
//   Inputs    : skewed array outputs, one element per column
//   IN_READY  : deskew block can advance this cycle
//   OUT_VALID : aligned row present on Outputs
//   OUT_READY : downstream accepts the aligned row
//   Outputs   : aligned row
//   OUT_LAST  : the presented row is the final row of the tile
// Modports: slave = deskew block view, master = upstream/downstream view.
interface systolic_result_deskew_if #(
  parameter int WIDTH  = 8,
  parameter int LENGTH = 256
);
  logic             IN_VALID;
  logic [WIDTH-1:0] Inputs [0:LENGTH-1];
  logic             IN_READY;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] Outputs [0:LENGTH-1];
  logic             OUT_LAST;

  modport slave (
    input  IN_VALID, Inputs, OUT_READY,
    output IN_READY, OUT_VALID, Outputs, OUT_LAST
  );

  modport master (
    output IN_VALID, Inputs, OUT_READY,
    input  IN_READY, OUT_VALID, Outputs, OUT_LAST
  );
endinterface

// File: rtl/systolic_result_deskew.sv
// systolic_result_deskew
// Realigns the skewed result wavefront leaving the bottom of a systolic
// array: column j arrives j cycles after column 0, so column j is delayed by
// LENGTH-1-j registers and all columns of a row meet in one vector. The
// aligned row is held in an output register behind a valid/ready handshake,
// rows are counted per tile and the final row of each tile is flagged.
// Ports:
//   CLK       : clock, rising edge
//   ASYNC_RST : asynchronous active-low reset
//   SYNC_RST  : synchronous active-high reset, same effect as ASYNC_RST
//   EN        : global advance enable shared with the array
//   TILE_ROWS : rows per tile (0 behaves as 1), stable during a tile
//   TILE_DONE : one-cycle pulse after the last row of a tile is accepted
//   bus       : row stream (see systolic_result_deskew_if)
module systolic_result_deskew #(
  parameter int WIDTH  = 8,
  parameter int LENGTH = 256,
  parameter int ROW_W  = 9
) (
  input  logic                  CLK,
  input  logic                  ASYNC_RST,
  input  logic                  SYNC_RST,
  input  logic                  EN,
  input  logic [ROW_W-1:0]      TILE_ROWS,
  output logic                  TILE_DONE,
  systolic_result_deskew_if.slave bus
);

  localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);

  logic             shift;
  logic             handshake;
  logic             aligned_valid;
  logic [WIDTH-1:0] aligned [0:LENGTH-1];
  logic [WIDTH-1:0] out_reg [0:LENGTH-1];
  logic             out_valid_reg;
  logic [ROW_W-1:0] cnt_reg;
  logic             tile_done_reg;
  logic [ROW_W-1:0] last_idx;
  logic             is_last;

  // The whole pipeline advances only when the output slot is free or being
  // drained this cycle, so a stalled row never gets overwritten.
  assign bus.IN_READY = ~out_valid_reg | bus.OUT_READY;
  assign shift        = EN & bus.IN_READY;
  assign handshake    = out_valid_reg & bus.OUT_READY;

  // TILE_ROWS == 0 behaves as a one-row tile.
  assign last_idx = (TILE_ROWS == '0) ? '0 : TILE_ROWS - ROW_ONE;
  assign is_last  = (cnt_reg == last_idx);

  genvar gi;
  generate
    // Inverse triangular delay: column gi waits LENGTH-1-gi shifts so that
    // it lines up with the last column, which arrives undelayed.
    for (gi = 0; gi < LENGTH; gi++) begin : g_col
      localparam int DEPTH = LENGTH - 1 - gi;
      if (DEPTH == 0) begin : g_direct
        assign aligned[gi] = bus.Inputs[gi];
      end else begin : g_delay
        logic [WIDTH-1:0] line_reg [0:DEPTH-1];
        always_ff @(posedge CLK or negedge ASYNC_RST) begin
          if (!ASYNC_RST) begin
            for (int k = 0; k < DEPTH; k++) line_reg[k] <= '0;
          end else if (SYNC_RST) begin
            for (int k = 0; k < DEPTH; k++) line_reg[k] <= '0;
          end else if (shift) begin
            line_reg[0] <= bus.Inputs[gi];
            for (int k = 1; k < DEPTH; k++) line_reg[k] <= line_reg[k-1];
          end
        end
        assign aligned[gi] = line_reg[DEPTH-1];
      end
    end

    // The row valid flag travels with column 0 and must wait as long as it.
    if (LENGTH == 1) begin : g_valid_direct
      assign aligned_valid = bus.IN_VALID;
    end else begin : g_valid_line
      logic valid_reg [0:LENGTH-2];
      always_ff @(posedge CLK or negedge ASYNC_RST) begin
        if (!ASYNC_RST) begin
          for (int k = 0; k < LENGTH - 1; k++) valid_reg[k] <= 1'b0;
        end else if (SYNC_RST) begin
          for (int k = 0; k < LENGTH - 1; k++) valid_reg[k] <= 1'b0;
        end else if (shift) begin
          valid_reg[0] <= bus.IN_VALID;
          for (int k = 1; k < LENGTH - 1; k++) valid_reg[k] <= valid_reg[k-1];
        end
      end
      assign aligned_valid = valid_reg[LENGTH-2];
    end
  endgenerate

  // Output slot. Loading wins over draining: when a row is accepted in the
  // same cycle a new aligned row arrives, the slot stays full.
  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      out_valid_reg <= 1'b0;
      for (int k = 0; k < LENGTH; k++) out_reg[k] <= '0;
    end else if (SYNC_RST) begin
      out_valid_reg <= 1'b0;
      for (int k = 0; k < LENGTH; k++) out_reg[k] <= '0;
    end else if (shift & aligned_valid) begin
      out_valid_reg <= 1'b1;
      for (int k = 0; k < LENGTH; k++) out_reg[k] <= aligned[k];
    end else if (handshake) begin
      // Draining does not depend on EN.
      out_valid_reg <= 1'b0;
    end
  end

  // Row counter within the current tile.
  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      cnt_reg       <= '0;
      tile_done_reg <= 1'b0;
    end else if (SYNC_RST) begin
      cnt_reg       <= '0;
      tile_done_reg <= 1'b0;
    end else begin
      tile_done_reg <= handshake & is_last;
      if (handshake) begin
        cnt_reg <= is_last ? '0 : cnt_reg + ROW_ONE;
      end
    end
  end

  assign bus.OUT_VALID = out_valid_reg;
  assign bus.Outputs   = out_reg;
  assign bus.OUT_LAST  = out_valid_reg & is_last;
  assign TILE_DONE     = tile_done_reg;

endmodule

// File: tb/tb_systolic_result_deskew.sv
// Bench for systolic_result_deskew: a LENGTH=4 instance driven with directed
// and random row streams against a row-level reference model, plus a
// LENGTH=1 instance with hand-computed expectations.
module tb_systolic_result_deskew;
  localparam int W  = 8;
  localparam int L  = 4;
  localparam int RW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          async_rst;
  logic          sync_rst;
  logic          en4, en1;
  logic [RW-1:0] tile_rows4, tile_rows1;
  logic          tile_done4, tile_done1;

  systolic_result_deskew_if #(.WIDTH(W), .LENGTH(L)) bus4 ();
  systolic_result_deskew_if #(.WIDTH(W), .LENGTH(1)) bus1 ();

  systolic_result_deskew #(.WIDTH(W), .LENGTH(L), .ROW_W(RW)) dut4 (
    .CLK(clk), .ASYNC_RST(async_rst), .SYNC_RST(sync_rst), .EN(en4),
    .TILE_ROWS(tile_rows4), .TILE_DONE(tile_done4), .bus(bus4)
  );

  systolic_result_deskew #(.WIDTH(W), .LENGTH(1), .ROW_W(RW)) dut1 (
    .CLK(clk), .ASYNC_RST(async_rst), .SYNC_RST(sync_rst), .EN(en1),
    .TILE_ROWS(tile_rows1), .TILE_DONE(tile_done1), .bus(bus1)
  );

  int checks = 0;
  int passes = 0;

  // Reference model: rows are numbered by the shift in which their column 0
  // enters; a row becomes visible L-1 shifts later.
  int          k = 0;           // index of the next row to enter
  int          floor_idx = 0;   // rows below this index were discarded by reset
  bit          hv [0:4095];
  logic [31:0] hd [0:4095];
  bit          mv;              // expected OUT_VALID
  logic [31:0] mdata;           // expected Outputs (column j in bits 8j+7:8j)
  int          acc;             // rows accepted in current tile
  bit          mtd;             // expected TILE_DONE
  logic [32:0] rq [$];          // pending rows {valid, data}
  int          done_pulses;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] dut_out();
    logic [31:0] r;
    for (int j = 0; j < L; j++) r[8*j +: 8] = bus4.Outputs[j];
    return r;
  endfunction

  task automatic model_reset();
    mv = 1'b0;
    acc = 0;
    mtd = 1'b0;
    floor_idx = k;
    rq.delete();
  endtask

  // One clock cycle on dut4: called at a negedge, returns at the next one.
  task automatic step(input bit en_i, input bit ordy_i, input bit srst_i);
    bit          sh, hs, lst, av;
    int          n, src, idx;
    logic [32:0] head;
    n    = (tile_rows4 == '0) ? 1 : int'(tile_rows4);
    sh   = en_i && (!mv || ordy_i);
    head = (rq.size() > 0) ? rq[0] : {1'b0, 32'($urandom())};
    en4            = en_i;
    bus4.OUT_READY = ordy_i;
    sync_rst       = srst_i;
    bus4.IN_VALID  = head[32];
    if (sh && !srst_i) begin
      hd[k] = head[31:0];
      for (int j = 0; j < L; j++) begin
        idx = k - j;
        bus4.Inputs[j] = (idx >= floor_idx) ? hd[idx][8*j +: 8] : 8'($urandom());
      end
    end else begin
      for (int j = 0; j < L; j++) bus4.Inputs[j] = 8'($urandom());
    end
    #1;
    lst = mv && (acc == n - 1);
    check("out_valid", 32'(bus4.OUT_VALID), 32'(mv));
    check("in_ready", 32'(bus4.IN_READY), 32'(!mv || ordy_i));
    check("out_last", 32'(bus4.OUT_LAST), 32'(lst));
    check("tile_done", 32'(tile_done4), 32'(mtd));
    if (mv) check("outputs", dut_out(), mdata);
    if (tile_done4) done_pulses++;
    if (srst_i) begin
      model_reset();
    end else begin
      hs  = mv && ordy_i;
      mtd = hs && lst;
      if (hs) acc = lst ? 0 : acc + 1;
      if (sh) begin
        hv[k] = head[32];
        if (rq.size() > 0) void'(rq.pop_front());
        src = k - (L - 1);
        av  = 1'b0;
        if (src >= floor_idx) av = hv[src];
        if (av) begin
          mv    = 1'b1;
          mdata = hd[src];
        end else if (hs) begin
          mv = 1'b0;
        end
        k++;
      end else if (hs) begin
        mv = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  localparam logic [32:0] ROW_A = {1'b1, 32'h04030201};
  localparam logic [32:0] ROW_B = {1'b1, 32'h08070605};
  localparam logic [32:0] ROW_C = {1'b1, 32'h0C0B0A09};
  localparam logic [32:0] GAP   = {1'b0, 32'h00000000};

  initial begin
    en4 = 1'b0; en1 = 1'b0; sync_rst = 1'b0;
    tile_rows4 = RW'(2); tile_rows1 = '0;
    bus4.IN_VALID = 1'b0; bus4.OUT_READY = 1'b0;
    bus1.IN_VALID = 1'b0; bus1.OUT_READY = 1'b0;
    for (int j = 0; j < L; j++) bus4.Inputs[j] = '0;
    bus1.Inputs[0] = '0;
    done_pulses = 0;
    async_rst = 1'b0;
    @(negedge clk);
    #1;
    check("reset_out_valid", 32'(bus4.OUT_VALID), 32'd0);
    check("reset_outputs", dut_out(), 32'd0);
    check("reset_tile_done", 32'(tile_done4), 32'd0);
    @(negedge clk);
    async_rst = 1'b1;
    model_reset();

    // Two-row tile, free-flowing.
    rq.push_back(ROW_A); rq.push_back(ROW_B);
    repeat (4) step(1, 1, 0);
    check("t1_a_valid", 32'(bus4.OUT_VALID), 32'd1);
    check("t1_a_data", dut_out(), 32'h04030201);
    check("t1_a_last", 32'(bus4.OUT_LAST), 32'd0);
    step(1, 1, 0);
    check("t1_b_data", dut_out(), 32'h08070605);
    check("t1_b_last", 32'(bus4.OUT_LAST), 32'd1);
    step(1, 1, 0);
    check("t1_done", 32'(tile_done4), 32'd1);
    check("t1_empty", 32'(bus4.OUT_VALID), 32'd0);
    step(1, 1, 0);
    check("t1_done_pulse", 32'(tile_done4), 32'd0);

    // Backpressure while A is presented.
    step(1, 1, 1);
    rq.push_back(ROW_A); rq.push_back(ROW_B);
    repeat (4) step(1, 1, 0);
    repeat (3) step(1, 0, 0);
    check("t2_hold_data", dut_out(), 32'h04030201);
    check("t2_in_ready", 32'(bus4.IN_READY), 32'd0);
    step(1, 1, 0);
    check("t2_b_data", dut_out(), 32'h08070605);
    repeat (3) step(1, 1, 0);

    // EN low while a row is pending: handshake still completes.
    step(1, 1, 1);
    rq.push_back(ROW_A); rq.push_back(ROW_B);
    repeat (4) step(1, 1, 0);
    step(0, 1, 0);
    check("t3_drained", 32'(bus4.OUT_VALID), 32'd0);
    step(0, 1, 0);
    step(1, 1, 0);
    check("t3_b_valid", 32'(bus4.OUT_VALID), 32'd1);
    check("t3_b_data", dut_out(), 32'h08070605);
    repeat (3) step(1, 1, 0);

    // Bubble pattern with single-row tiles.
    step(1, 1, 1);
    tile_rows4 = '0;
    done_pulses = 0;
    rq.push_back(ROW_A); rq.push_back(GAP); rq.push_back(ROW_C);
    repeat (9) step(1, 1, 0);
    check("t4_done_pulses", 32'(done_pulses), 32'd2);

    // Asynchronous reset with a row held and another half shifted in.
    step(1, 1, 1);
    tile_rows4 = RW'(2);
    rq.push_back(ROW_A); rq.push_back(ROW_B); rq.push_back(ROW_C);
    repeat (4) step(1, 1, 0);
    step(1, 0, 0);
    #2 async_rst = 1'b0;
    #1;
    check("t5_async_valid", 32'(bus4.OUT_VALID), 32'd0);
    check("t5_async_outputs", dut_out(), 32'd0);
    check("t5_async_last", 32'(bus4.OUT_LAST), 32'd0);
    @(negedge clk);
    async_rst = 1'b1;
    model_reset();
    repeat (6) step(1, 1, 0);
    rq.push_back(ROW_C); rq.push_back(ROW_A);
    repeat (6) step(1, 1, 0);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      bit rst_now;
      if (rq.size() < 3 && $urandom_range(0, 1) == 1)
        rq.push_back({($urandom_range(0, 3) != 0), 32'($urandom())});
      rst_now = ($urandom_range(0, 99) == 0);
      step(($urandom_range(0, 4) != 0), ($urandom_range(0, 3) != 0), rst_now);
      if (rst_now) tile_rows4 = RW'($urandom_range(0, 5));
    end
    en4 = 1'b0;

    // LENGTH=1 instance.
    bus1.Inputs[0] = 8'h5A; bus1.IN_VALID = 1'b1; bus1.OUT_READY = 1'b1; en1 = 1'b1;
    @(posedge clk); @(negedge clk);
    check("l1_valid", 32'(bus1.OUT_VALID), 32'd1);
    check("l1_data", 32'(bus1.Outputs[0]), 32'h5A);
    check("l1_last", 32'(bus1.OUT_LAST), 32'd1);
    bus1.Inputs[0] = 8'hA5; bus1.OUT_READY = 1'b0;
    #1;
    check("l1_in_ready", 32'(bus1.IN_READY), 32'd0);
    @(posedge clk); @(negedge clk);
    check("l1_hold", 32'(bus1.Outputs[0]), 32'h5A);
    bus1.OUT_READY = 1'b1;
    @(posedge clk); @(negedge clk);
    check("l1_next", 32'(bus1.Outputs[0]), 32'hA5);
    check("l1_done", 32'(tile_done1), 32'd1);
    bus1.IN_VALID = 1'b0;
    @(posedge clk); @(negedge clk);
    check("l1_empty", 32'(bus1.OUT_VALID), 32'd0);
    check("l1_done2", 32'(tile_done1), 32'd1);
    @(posedge clk); @(negedge clk);
    check("l1_done_end", 32'(tile_done1), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/systolic_result_deskew.md
Name: systolic_result_deskew

Overview:
- Sits directly downstream of the systolic PE array and consumes the skewed result wavefront leaving its bottom edge.
- The array emits column j's element of a result row j cycles after column 0's element.
- This block applies the inverse triangular delay, so that every column of a row is realigned into one vector.
- It presents the realigned rows on a valid/ready interface, counts rows per tile, and flags the last row of each tile.

Parameters:
- WIDTH, 8, bit width of one result element.
- LENGTH, 256, number of array columns (vector length); must be >= 1.
- ROW_W, 9, width of the tile row-count input and the internal row counter.

Ports:
- CLK  in  1  clock, rising edge.
- ASYNC_RST  in  1  asynchronous, active-low reset.
- SYNC_RST  in  1  synchronous, active-high reset; same effect as ASYNC_RST, applied at the clock edge.
- EN  in  1  global advance enable; shared with the array.
- IN_VALID  in  1  marks the column-0 element of a result row on Inputs[0] this cycle.
- Inputs  in  WIDTH x [0:LENGTH-1]  skewed array outputs, one element per column.
- IN_READY  out  1  combinational, ~OUT_VALID | OUT_READY; upstream advances only when EN & IN_READY.
- TILE_ROWS  in  ROW_W  rows per tile; quasi-static, must be stable during a tile; 0 is treated as 1.
- OUT_VALID  out  1  aligned row available.
- OUT_READY  in  1  downstream accepts the row.
- Outputs  out  WIDTH x [0:LENGTH-1]  aligned row.
- OUT_LAST  out  1  OUT_VALID and the current row is the final row of the tile.
- TILE_DONE  out  1  one-cycle pulse after the last row of a tile is accepted.

Behaviour:
- shift = EN & IN_READY. All delay lines advance only when shift is high; otherwise they hold.
- Column j delay line: a chain of D_j = LENGTH-1-j registers.
  - Column LENGTH-1 has zero depth and feeds the aligned vector directly.
  - LENGTH=1 means no delay registers.
- Valid delay line: LENGTH-1 flops. IN_VALID enters together with Inputs[0]; the aligned vector is valid when the tail flop is 1 (IN_VALID itself when LENGTH=1).
- Output register, on each edge:
  - If shift & aligned-valid: load Outputs with the aligned vector and set OUT_VALID=1.
  - Else if OUT_VALID & OUT_READY: clear OUT_VALID. This applies even when EN=0; the handshake is independent of EN.
  - Otherwise hold. Outputs never change while OUT_VALID=1 and OUT_READY=0.
- Latency: with uninterrupted shift, a row whose column 0 arrives at edge t shows OUT_VALID=1 after edge t+LENGTH-1. Column j of that row is sampled at edge t+j.
- Backpressure: when OUT_VALID=1 and OUT_READY=0, IN_READY=0. The whole pipeline freezes with no loss or duplication.
- Throughput: with OUT_READY held at 1, the block sustains one row per cycle.
- Row counter cnt (ROW_W bits), with N = max(TILE_ROWS, 1):
  - Increments on each handshake (OUT_VALID & OUT_READY).
  - OUT_LAST = OUT_VALID & (cnt == N-1).
  - The handshake with OUT_LAST wraps cnt to 0 and sets TILE_DONE=1 for the next cycle only.
- Reset: ASYNC_RST low, or SYNC_RST high at an edge, clears:
  - all delay registers to 0;
  - the valid line;
  - Outputs to 0;
  - OUT_VALID=0, cnt=0, TILE_DONE=0.
  - Reset mid-tile discards all in-flight rows; SYNC_RST has priority over EN.
- Bubbles: IN_VALID=0 cycles create gaps that propagate unchanged; the data in a gap is don't-care but must not assert OUT_VALID.

Test Plan:
- LENGTH=4, WIDTH=8, OUT_READY=1, EN=1, TILE_ROWS=2. Drive skewed rows A=(1,2,3,4) and B=(5,6,7,8): column j of row r at edge r+j. -> Outputs=(1,2,3,4) valid after edge 3 and (5,6,7,8) after edge 4; OUT_LAST on B; TILE_DONE pulses once.
- Same stream with OUT_READY=0 for 3 cycles while A is presented. -> IN_READY=0; Outputs hold (1,2,3,4); after release, B follows with no loss or duplicate.
- EN=0 for 2 cycles mid-stream with OUT_READY=1. -> delay lines hold; a pending OUT_VALID still completes its handshake; alignment is intact afterwards.
- IN_VALID pattern 1,0,1 with TILE_ROWS=0. -> two valid rows separated by a one-cycle OUT_VALID gap; every row has OUT_LAST=1 and TILE_DONE pulses twice.
- ASYNC_RST asserted low while row A is half shifted in. -> outputs are 0 immediately; no OUT_VALID after release until new input; cnt=0.
- LENGTH=1, IN_VALID=1 with Inputs[0]=0x5A. -> Outputs[0]=0x5A and OUT_VALID=1 after one edge.
